// File: rtl/truth_table_extractor.sv
// truth_table_extractor
//
// Purpose:
//   Walks every input combination of a small combinational circuit under test.
//   For each vector it waits SETTLE cycles, then samples all outputs into a
//   capture buffer. Once every vector has been applied, the block streams one
//   truth table per output over a valid/ready interface, in index order.
//
// Parameters:
//   NUM_IN   number of circuit inputs driven (1..6)
//   NUM_OUT  number of circuit outputs sampled (1..64)
//   SETTLE   clock cycles between applying a vector and sampling (>=1)
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         begin extraction (accepted only while idle)
//   abort         synchronous abort back to idle, highest priority
//   x_drv         registered input vector to the circuit (bit0 = x0)
//   f_in          circuit outputs (bit0 = f1)
//   busy          high whenever not idle
//   tt_valid      truth-table word valid
//   tt_ready      consumer ready
//   tt_idx        output index of the current word (0 = f1)
//   tt_data       truth table; bit k = output value when x_drv == k
//   done          one-cycle pulse after the last word is accepted
//   tt_const      (TT_CONST_FLAG_EN only) tt_data is all-zeros or all-ones
//   tt_const_val  (TT_CONST_FLAG_EN only) constant value, equals tt_data[0]
//
// Optional feature macro: TT_CONST_FLAG_EN

module truth_table_extractor #(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 19,
    parameter int SETTLE  = 1,
    localparam int VECS   = 1 << NUM_IN,
    localparam int IDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [NUM_IN-1:0]  x_drv,
    input  logic [NUM_OUT-1:0] f_in,
    output logic               busy,
    output logic               tt_valid,
    input  logic               tt_ready,
    output logic [IDX_W-1:0]   tt_idx,
    output logic [VECS-1:0]    tt_data,
`ifdef TT_CONST_FLAG_EN
    output logic               tt_const,
    output logic               tt_const_val,
`endif
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_EMIT,
        S_FINISH
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

    state_t                         state;
    logic [NUM_OUT-1:0][VECS-1:0]   tt_buf;
    logic [CNT_W-1:0]               settle_cnt;
    logic [IDX_W-1:0]               next_idx;
    logic [VECS-1:0]                load_row;
    logic                           load_const;

    // Word to present next. While capturing, the only load happens on the
    // final sample edge, when the last column of row 0 is still on f_in and
    // not yet in the buffer, so it is merged in directly. While emitting,
    // the next word is simply the following buffer row.
    always_comb begin
        next_idx = tt_idx + IDX_W'(1);
        load_row = tt_buf[next_idx];
        if (state == S_APPLY) begin
            load_row         = tt_buf[0];
            load_row[VECS-1] = f_in[0];
        end
        load_const = (&load_row) | (~|load_row);
    end

    // Controller, capture buffer and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tt_buf     <= '0;
            settle_cnt <= '0;
            x_drv      <= '0;
            busy       <= 1'b0;
            tt_valid   <= 1'b0;
            tt_idx     <= '0;
            tt_data    <= '0;
            done       <= 1'b0;
`ifdef TT_CONST_FLAG_EN
            tt_const     <= 1'b0;
            tt_const_val <= 1'b0;
`endif
        end else if (abort) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            x_drv      <= '0;
            busy       <= 1'b0;
            tt_valid   <= 1'b0;
            tt_idx     <= '0;
            tt_data    <= '0;
            done       <= 1'b0;
`ifdef TT_CONST_FLAG_EN
            tt_const     <= 1'b0;
            tt_const_val <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_APPLY;
                        busy       <= 1'b1;
                        x_drv      <= '0;
                        settle_cnt <= '0;
                    end
                end

                S_APPLY: begin
                    if (settle_cnt == LAST_CNT) begin
                        settle_cnt <= '0;
                        // Column write: one bit per output at position x_drv.
                        for (int o = 0; o < NUM_OUT; o++) begin
                            tt_buf[o][x_drv] <= f_in[o];
                        end
                        if (x_drv == '1) begin
                            state    <= S_EMIT;
                            x_drv    <= '0;
                            tt_valid <= 1'b1;
                            tt_idx   <= '0;
                            tt_data  <= load_row;
`ifdef TT_CONST_FLAG_EN
                            tt_const     <= load_const;
                            tt_const_val <= load_row[0];
`endif
                        end else begin
                            x_drv <= x_drv + NUM_IN'(1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                S_EMIT: begin
                    if (tt_ready) begin
                        if (tt_idx == LAST_IDX) begin
                            state    <= S_FINISH;
                            tt_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            tt_idx  <= next_idx;
                            tt_data <= load_row;
`ifdef TT_CONST_FLAG_EN
                            tt_const     <= load_const;
                            tt_const_val <= load_row[0];
`endif
                        end
                    end
                end

                S_FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef TT_CONST_FLAG_EN
    // The constant flag is only consumed when the optional outputs exist.
    logic unused_const;
    assign unused_const = load_const;
`endif

endmodule
